// File: rtl/sprite_line_renderer_pkg.sv
// Shared types and constants for the tank-game sprite line renderer.
// Object kinds, render FSM states and video geometry.
package game_pkg;

  localparam int SPR_SIZE = 32;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    OBJ_NONE   = 2'd0,
    OBJ_TANK   = 2'd1,
    OBJ_BULLET = 2'd2,
    OBJ_BRICK  = 2'd3
  } obj_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_DRAW,
    ST_NEXT
  } render_st_t;

endpackage

// File: rtl/sprite_line_renderer_if.sv
// Object-table read bus and sprite bitmap lookup bus.
// master = renderer, slave = table/bitmap side.
interface sprite_line_renderer_if;

  logic [3:0] obj_sel;
  logic [9:0] obj_x;
  logic [9:0] obj_y;
  logic [1:0] obj_dir;
  logic [1:0] obj_kind;
  logic [4:0] spr_x;
  logic [4:0] spr_y;
  logic [1:0] spr_dir;
  logic       spr_bul;
  logic       spr_brk;
  logic       spr_pixel;

  modport master (
    output obj_sel,
    input  obj_x, obj_y, obj_dir, obj_kind,
    output spr_x, spr_y, spr_dir,
    output spr_bul, spr_brk,
    input  spr_pixel
  );

  modport slave (
    input  obj_sel,
    output obj_x, obj_y, obj_dir, obj_kind,
    input  spr_x, spr_y, spr_dir,
    input  spr_bul, spr_brk,
    output spr_pixel
  );

endinterface

// File: rtl/line_buffer_pp.sv
// Ping-pong line buffer: back half written by the renderer, front half
// read and cleared by the display. COLLISION_DETECT_EN exposes prev entry.
module line_buffer_pp
  import game_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            swap,
  input  logic            we,
  input  logic [9:0]      waddr,
  input  logic [ID_W-1:0] wdata,
`ifdef COLLISION_DETECT_EN
  output logic [ID_W-1:0] wprev,
`endif
  input  logic            rd,
  input  logic [9:0]      raddr,
  output logic [ID_W-1:0] rdata
);

  logic [ID_W-1:0] mem [2][H_ACTIVE];
  logic            sel;

  assign rdata = mem[sel][raddr];
`ifdef COLLISION_DETECT_EN
  assign wprev = mem[~sel][waddr];
`endif

  // Writes and clears land on the halves selected before any swap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < H_ACTIVE; i++)
          mem[b][i] <= '0;
    end else begin
      if (swap) sel <= ~sel;
      if (we)   mem[~sel][waddr] <= wdata;
      if (rd)   mem[sel][raddr]  <= '0;
    end
  end

endmodule

// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite rasteriser: renders line N+1 while line N shows.
// Optional COLLISION_DETECT_EN adds coll_valid/coll_a/coll_b.
module sprite_line_renderer
  import game_pkg::*;
#(
  parameter int NUM_OBJ = 15,
  parameter int ID_W    = 4
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            line_start,
  input  logic [9:0]      next_line,
  sprite_line_renderer_if.master bus,
  input  logic [9:0]      disp_x,
  input  logic            disp_valid,
  output logic [ID_W-1:0] disp_id,
  output logic            busy,
  output logic            overrun
`ifdef COLLISION_DETECT_EN
  ,
  output logic            coll_valid,
  output logic [ID_W-1:0] coll_a,
  output logic [ID_W-1:0] coll_b
`endif
);

  render_st_t st;
  obj_kind_t  kind;
  logic [3:0] obj;
  logic [9:0] cur_line;
  logic [9:0] ox;
  logic [9:0] dy;
  logic [1:0] dir;
  logic [4:0] col;

  logic [10:0]     wsum;
  logic            we;
  logic [ID_W-1:0] wdata;
  logic            rd;
  logic [ID_W-1:0] rdata;

  assign busy        = (st != ST_IDLE);
  assign bus.obj_sel = obj;
  assign bus.spr_x   = col;
  assign bus.spr_y   = dy[4:0];
  assign bus.spr_dir = dir;
  assign bus.spr_bul = (kind == OBJ_BULLET);
  assign bus.spr_brk = (kind == OBJ_BRICK);

  // 11-bit sum so sprites past the right edge clip instead of wrapping.
  assign wsum  = {1'b0, ox} + {6'b0, col};
  assign we    = (st == ST_DRAW) && bus.spr_pixel
              && (wsum < 11'(H_ACTIVE)) && !line_start;
  assign wdata = ID_W'(obj + 4'd1);
  assign rd    = disp_valid && (disp_x < 10'(H_ACTIVE));

`ifdef COLLISION_DETECT_EN
  logic [ID_W-1:0] wprev;
`endif

  line_buffer_pp #(.ID_W(ID_W)) u_lbuf (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .swap    (line_start),
    .we      (we),
    .waddr   (wsum[9:0]),
    .wdata   (wdata),
`ifdef COLLISION_DETECT_EN
    .wprev   (wprev),
`endif
    .rd      (rd),
    .raddr   (disp_x),
    .rdata   (rdata)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st       <= ST_IDLE;
      kind     <= OBJ_NONE;
      obj      <= '0;
      cur_line <= '0;
      ox       <= '0;
      dy       <= '0;
      dir      <= '0;
      col      <= '0;
      overrun  <= 1'b0;
    end else if (line_start) begin
      cur_line <= next_line;
      if (busy) overrun <= 1'b1;
      if (next_line < 10'(V_ACTIVE)) begin
        st  <= ST_FETCH;
        obj <= 4'(NUM_OBJ - 1);
      end else begin
        st  <= ST_IDLE;
      end
    end else begin
      unique case (st)
        ST_IDLE: ;
        ST_FETCH: begin
          ox   <= bus.obj_x;
          dir  <= bus.obj_dir;
          kind <= obj_kind_t'(bus.obj_kind);
          dy   <= cur_line - bus.obj_y;
          st   <= ST_CHECK;
        end
        ST_CHECK: begin
          if (kind != OBJ_NONE && dy[9:5] == '0) begin
            col <= '0;
            st  <= ST_DRAW;
          end else begin
            st  <= ST_NEXT;
          end
        end
        ST_DRAW: begin
          col <= col + 5'd1;
          if (col == 5'(SPR_SIZE - 1)) st <= ST_NEXT;
        end
        ST_NEXT: begin
          if (obj == '0) begin
            st  <= ST_IDLE;
          end else begin
            obj <= obj - 4'd1;
            st  <= ST_FETCH;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) disp_id <= '0;
    else          disp_id <= rd ? rdata : '0;
  end

`ifdef COLLISION_DETECT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      coll_valid <= 1'b0;
      coll_a     <= '0;
      coll_b     <= '0;
    end else begin
      coll_valid <= we && (wprev != '0);
      if (we && wprev != '0) begin
        coll_a <= wdata;
        coll_b <= wprev;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer.
// Object table and bitmap are modelled as small arrays.
module tb_sprite_line_renderer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] next_line = '0;
  logic [9:0] disp_x = '0;
  logic       disp_valid = 1'b0;
  logic [3:0] disp_id;
  logic       busy;
  logic       overrun;
`ifdef COLLISION_DETECT_EN
  logic       coll_valid;
  logic [3:0] coll_a;
  logic [3:0] coll_b;
  logic       coll_seen;
  logic [3:0] cap_ca;
  logic [3:0] cap_cb;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [9:0]  tx [16];
  logic [9:0]  ty [16];
  logic [1:0]  tdir [16];
  logic [1:0]  tkind [16];
  logic [31:0] bmp [32];

  logic [4:0] cap_y;
  logic [1:0] cap_dir;
  logic       cap_brk;

  sprite_line_renderer_if bus();

  assign bus.obj_x     = tx[bus.obj_sel];
  assign bus.obj_y     = ty[bus.obj_sel];
  assign bus.obj_dir   = tdir[bus.obj_sel];
  assign bus.obj_kind  = tkind[bus.obj_sel];
  assign bus.spr_pixel = bmp[bus.spr_y][bus.spr_x];

  sprite_line_renderer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .line_start (line_start),
    .next_line  (next_line),
    .bus        (bus.master),
    .disp_x     (disp_x),
    .disp_valid (disp_valid),
    .disp_id    (disp_id),
    .busy       (busy),
    .overrun    (overrun)
`ifdef COLLISION_DETECT_EN
    ,
    .coll_valid (coll_valid),
    .coll_a     (coll_a),
    .coll_b     (coll_b)
`endif
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (busy && bus.spr_x == 5'd5) begin
      cap_y   <= bus.spr_y;
      cap_dir <= bus.spr_dir;
      cap_brk <= bus.spr_brk;
    end
  end

`ifdef COLLISION_DETECT_EN
  always @(posedge Clk) begin
    if (!Reset_n) begin
      coll_seen <= 1'b0;
    end else if (coll_valid) begin
      coll_seen <= 1'b1;
      cap_ca    <= coll_a;
      cap_cb    <= coll_b;
    end
  end
`endif

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic clr_tbl();
    for (int i = 0; i < 16; i++) begin
      tx[i] = '0; ty[i] = '0; tdir[i] = '0; tkind[i] = '0;
    end
    for (int r = 0; r < 32; r++) bmp[r] = '0;
    bmp[3] = 32'hFFFF_FFFF;
  endtask

  task automatic set_obj(input int i, input int x, input int y,
                         input int d, input int k);
    tx[i] = 10'(x); ty[i] = 10'(y);
    tdir[i] = 2'(d); tkind[i] = 2'(k);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic pulse_ls(input int y);
    @(negedge Clk);
    line_start = 1'b1;
    next_line  = 10'(y);
    @(negedge Clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    check_eq("render_done", 32'(busy), 0);
  endtask

  task automatic rd(input string tag, input int x, input int want);
    @(negedge Clk);
    disp_valid = 1'b1;
    disp_x     = 10'(x);
    @(posedge Clk);
    #1;
    check_eq(tag, 32'(disp_id), 32'(want));
    disp_valid = 1'b0;
  endtask

  task automatic scan(output int nz);
    nz = 0;
    for (int x = 0; x < 640; x++) begin
      @(negedge Clk);
      disp_valid = 1'b1;
      disp_x     = 10'(x);
      @(posedge Clk);
      #1;
      if (disp_id != 0) nz++;
    end
    disp_valid = 1'b0;
  endtask

  initial begin
    int nz;
    int n;
    clr_tbl();
    repeat (3) @(negedge Clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_disp_id", 32'(disp_id), 0);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_eq("rst_overrun", 32'(overrun), 0);
    check_eq("rst_obj_sel", 32'(bus.obj_sel), 0);
    check_eq("rst_spr_x", 32'(bus.spr_x), 0);

    // single tank, row 3 of its sprite on line 53
    set_obj(0, 100, 50, 2, 1);
    pulse_ls(53);
    check_eq("t1_busy", 32'(busy), 1);
    wait_idle();
    check_eq("t1_spr_y", 32'(cap_y), 3);
    check_eq("t1_spr_dir", 32'(cap_dir), 2);
    pulse_ls(490);
    check_eq("t1_idle", 32'(busy), 0);
    rd("t1_x99", 99, 0);
    rd("t1_x100", 100, 1);
    rd("t1_x115", 115, 1);
    rd("t1_x131", 131, 1);
    rd("t1_x132", 132, 0);
    rd("t1_x100_clr", 100, 0);
    @(posedge Clk); #1;
    check_eq("t1_valid_low", 32'(disp_id), 0);

    // overlap: obj index 0 (id 1) beats obj index 3 (id 4)
    do_reset();
    clr_tbl();
    set_obj(0, 200, 50, 0, 1);
    set_obj(3, 190, 50, 0, 1);
    pulse_ls(53);
    wait_idle();
    pulse_ls(490);
    rd("t2_x189", 189, 0);
    rd("t2_x195", 195, 4);
    rd("t2_x200", 200, 1);
    rd("t2_x221", 221, 1);
    rd("t2_x225", 225, 1);
`ifdef COLLISION_DETECT_EN
    check_eq("t2_coll_seen", 32'(coll_seen), 1);
    check_eq("t2_coll_a", 32'(cap_ca), 1);
    check_eq("t2_coll_b", 32'(cap_cb), 4);
`endif

    // brick clipped at the right edge
    do_reset();
    clr_tbl();
    set_obj(2, 620, 50, 0, 3);
    pulse_ls(53);
    wait_idle();
    check_eq("t3_spr_brk", 32'(cap_brk), 1);
    pulse_ls(490);
    rd("t3_x619", 619, 0);
    rd("t3_x620", 620, 3);
    rd("t3_x639", 639, 3);
    rd("t3_x0", 0, 0);
    rd("t3_x11", 11, 0);
    rd("t3_x700", 700, 0);

    // blank line request and clear-on-read
    do_reset();
    clr_tbl();
    set_obj(0, 100, 50, 2, 1);
    pulse_ls(53);
    wait_idle();
    pulse_ls(490);
    check_eq("t4_blank_busy", 32'(busy), 0);
    scan(nz);
    check_eq("t4_count", 32'(nz), 32);
    pulse_ls(490);
    pulse_ls(490);
    check_eq("t4_blank_busy2", 32'(busy), 0);
    scan(nz);
    check_eq("t4_cleared", 32'(nz), 0);

    // overrun: second line_start mid-render
    do_reset();
    clr_tbl();
    for (int i = 0; i < 15; i++) set_obj(i, 300, 50, 0, 1);
    pulse_ls(53);
    repeat (100) @(negedge Clk);
    check_eq("t5_busy", 32'(busy), 1);
    check_eq("t5_no_ovr", 32'(overrun), 0);
    pulse_ls(53);
    check_eq("t5_overrun", 32'(overrun), 1);
    check_eq("t5_restart", 32'(bus.obj_sel), 14);
    wait_idle();
    check_eq("t5_sticky", 32'(overrun), 1);
    pulse_ls(490);
    rd("t5_x300", 300, 1);
    rd("t5_x331", 331, 1);
    rd("t5_x332", 332, 0);

    // reset in the middle of DRAW
    clr_tbl();
    set_obj(0, 100, 50, 2, 1);
    pulse_ls(53);
    n = 0;
    while (!(busy && bus.spr_x == 5'd10) && n < 500) begin
      @(negedge Clk);
      n++;
    end
    check_eq("t6_in_draw", 32'(bus.spr_x), 10);
    #2;
    Reset_n = 1'b0;
    #1;
    check_eq("t6_busy", 32'(busy), 0);
    check_eq("t6_overrun", 32'(overrun), 0);
    check_eq("t6_disp_id", 32'(disp_id), 0);
    check_eq("t6_obj_sel", 32'(bus.obj_sel), 0);
    check_eq("t6_spr_x", 32'(bus.spr_x), 0);
    check_eq("t6_spr_dir", 32'(bus.spr_dir), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    rd("t6_x100_rst", 100, 0);
    rd("t6_x105_rst", 105, 0);
    pulse_ls(53);
    wait_idle();
    pulse_ls(490);
    rd("t6_x100", 100, 1);
    rd("t6_x131", 131, 1);
    rd("t6_x132", 132, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
- Per-scanline sprite rasteriser for the tank game.
- During display of line N, it walks the object table and renders line N+1 into the back half of a ping-pong line buffer. It drives the 32x32 sprite bitmap lookup stage one column per cycle.
- During active video it returns a per-pixel object ID to the colour mapper. ID 0 means background.

Parameters:
- NUM_OBJ, 15, number of object-table entries. IDs are 1..NUM_OBJ; the maximum is 15.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- ID_W, 4, bits per line-buffer entry.

Ports:
- Clk  in  1  system/pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- line_start  in  1  one-cycle pulse at the start of every line (active or blank)
- next_line  in  10  Y of the line to render; sampled on line_start
- obj_sel  out  4  object-table read index (table read is combinational)
- obj_x  in  10  left edge of the selected object
- obj_y  in  10  top edge of the selected object
- obj_dir  in  2  facing of the selected object, 0..3
- obj_kind  in  2  0 = inactive, 1 = tank, 2 = bullet, 3 = brick
- spr_x  out  5  column within the sprite, to the bitmap lookup stage
- spr_y  out  5  row within the sprite
- spr_dir  out  2  sprite facing
- spr_bul  out  1  bullet bitmap select
- spr_brk  out  1  brick bitmap select
- spr_pixel  in  1  bitmap bit; combinational same-cycle return
- disp_x  in  10  current display X
- disp_valid  in  1  active-video strobe
- disp_id  out  4  object ID at disp_x; registered, 1-cycle latency
- busy  out  1  render in progress
- overrun  out  1  sticky; set when line_start arrives while busy

Behaviour:
- Reset (async, Reset_n=0): FSM to IDLE; both buffers cleared to 0; front buffer select = 0. All outputs 0: disp_id, busy, overrun, obj_sel, all spr_* signals.
- line_start:
  - Swaps front/back buffers.
  - Latches next_line.
  - If next_line < V_ACTIVE, enters FETCH with obj = NUM_OBJ-1; otherwise stays IDLE.
  - If busy at that moment: the render aborts (the partial buffer is still swapped to front), overrun is set, and the new render starts. line_start has priority over every FSM transition.
- Objects are processed in descending index order, so lower indices overwrite and win priority.
- FSM states:
  - IDLE: waits for line_start.
  - FETCH (1 cycle): obj_sel = obj; attributes registered; dy = line - obj_y (10-bit unsigned).
  - CHECK (1 cycle): if kind != 0 and dy < 32, go to DRAW with col = 0. Otherwise go to NEXT.
  - DRAW (32 cycles):
    - Drives spr_x = col, spr_y = dy[4:0], spr_dir = dir, spr_bul = (kind==2), spr_brk = (kind==3).
    - If spr_pixel = 1 and obj_x + col < H_ACTIVE (11-bit sum; no wrap), back[obj_x + col] <= obj+1.
    - col increments each cycle; after col = 31, go to NEXT.
  - NEXT: if obj == 0, go to IDLE; otherwise obj-1, then FETCH.
- busy = (state != IDLE).
- Worst-case render time is NUM_OBJ*35 = 525 cycles, less than an 800-cycle line.
- Display side:
  - When disp_valid = 1 and disp_x < H_ACTIVE: disp_id <= front[disp_x] on the next cycle, and front[disp_x] is cleared to 0 in the same cycle (clear-on-read).
  - Otherwise disp_id <= 0.
  - Back-buffer writes and front-buffer reads/clears never address the same buffer.
- overrun is cleared only by reset.

Optional Feature:
- Macro: COLLISION_DETECT_EN.
- Defined:
  - Adds outputs coll_valid (1), coll_a (4), coll_b (4).
  - On any DRAW write whose target entry is nonzero, coll_valid pulses for 1 cycle with coll_a = obj+1 and coll_b = the previous entry.
  - If several collisions occur, the last one in a cycle stream is reported each cycle.
- Undefined: no extra ports or logic; writes overwrite silently.

Decomposition:
- Package game_pkg:
  - obj_kind_t enum (OBJ_NONE, OBJ_TANK, OBJ_BULLET, OBJ_BRICK).
  - render-state enum.
  - constants SPR_SIZE = 32, H_ACTIVE, V_ACTIVE.
- One sub-module: line_buffer_pp. It holds the two H_ACTIVE x ID_W arrays, the swap select, the write port (back buffer) and the clear-on-read port (front buffer). The FSM stays in the top.

Test Plan:
- Tank id 1 at (100,50), dir 2, bitmap row 3 all ones; line_start with next_line = 53 -> after the swap, disp_x 100..131 gives disp_id = 1 and disp_x 99/132 gives 0. Each result appears one cycle after disp_valid.
- Object 1 and object 4 both covering x = 200 on the same line -> disp_id = 1. With COLLISION_DETECT_EN: coll_valid with coll_a = 1, coll_b = 4.
- Brick at obj_x = 620 with a full row -> entries 620..639 written; no write for x >= 640; no wrap to x = 0..11.
- next_line = 490 -> FSM stays IDLE, busy stays 0; the following displayed line reads all zeros (cleared by the prior read).
- Second line_start 100 cycles after the first, with 15 active overlapping objects -> overrun = 1 and sticky; the render restarts from obj 14.
- Assert Reset_n = 0 in the middle of DRAW -> all buffer entries and outputs read 0 and the FSM is IDLE; after release, the next line_start renders normally.
